// File: rtl/vga_defs_pkg.sv
// Shared VGA adapter definitions: screen geometry, coordinate/colour widths,
// named colours and the blitter state encoding.
package vga_defs;

    localparam int VGA_SCREEN_W = 320;
    localparam int VGA_SCREEN_H = 240;
    localparam int X_W          = 9;
    localparam int Y_W          = 8;
    localparam int COLOUR_W     = 3;

    localparam logic [COLOUR_W-1:0] RED   = 3'b100;
    localparam logic [COLOUR_W-1:0] GREEN = 3'b010;
    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;
    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } blit_state_t;

    // Widened coordinates so an overflowing sprite edge is clipped, never wrapped.
    function automatic logic on_screen(
        input logic [X_W:0] px,
        input logic [Y_W:0] py,
        input int           scr_w,
        input int           scr_h
    );
        logic [X_W:0] w_lim_x;
        logic [Y_W:0] w_lim_y;
        w_lim_x = scr_w[X_W:0];
        w_lim_y = scr_h[Y_W:0];
        return (px < w_lim_x) && (py < w_lim_y);
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// Sprite bitmap with a registered read port; the default pattern is a red
// one-pixel border around a transparent interior.
module sprite_rom
    import vga_defs::*;
#(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8
) (
    input  logic                                            clock,
    input  logic [$clog2(SPRITE_H)+$clog2(SPRITE_W)-1:0]    addr,
    output logic [COLOUR_W-1:0]                             colour
);

    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);

    logic [RW-1:0]       w_row;
    logic [CW-1:0]       w_col;
    logic [COLOUR_W-1:0] r_colour;

    function automatic logic [COLOUR_W-1:0] pixel_at(
        input logic [RW-1:0] row,
        input logic [CW-1:0] col
    );
        if ((row == {RW{1'b0}}) || (row == ROW_LAST) ||
            (col == {CW{1'b0}}) || (col == COL_LAST)) begin
            return RED;
        end else begin
            return BLACK;
        end
    endfunction

    always_comb begin
        w_row = addr[RW+CW-1:CW];
        w_col = addr[CW-1:0];
    end

    always_ff @(posedge clock) begin
        r_colour <= pixel_at(w_row, w_col);
    end

    assign colour = r_colour;

endmodule

// File: rtl/sprite_blitter.sv
// Turns one "draw sprite at (x,y)" request into a stream of single-pixel
// writes, skipping transparent and off-screen pixels; erase repaints the footprint.
module sprite_blitter
    import vga_defs::*;
#(
    parameter int                  SPRITE_W    = 8,
    parameter int                  SPRITE_H    = 8,
    parameter int                  SCREEN_W    = VGA_SCREEN_W,
    parameter int                  SCREEN_H    = VGA_SCREEN_H,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = BLACK,
    parameter logic [COLOUR_W-1:0] BG_COLOUR   = WHITE
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic                erase,
    output logic                busy,
    output logic                done,
    output logic                plot,
    output logic [COLOUR_W-1:0] colour,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y
);

    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    blit_state_t         r_state;
    logic [RW-1:0]       r_row;
    logic [CW-1:0]       r_col;
    logic                r_flush_cnt;
    logic [X_W-1:0]      r_x0;
    logic [Y_W-1:0]      r_y0;
    logic                r_erase;
    logic                r_busy;
    logic                r_done;

    logic                w_issue;
    logic [RW+CW-1:0]    w_addr;
    logic [COLOUR_W-1:0] w_rom_colour;

    logic                r_s1_valid;
    logic [RW-1:0]       r_s1_row;
    logic [CW-1:0]       r_s1_col;

    logic [X_W:0]        w_px;
    logic [Y_W:0]        w_py;
    logic                w_plot;
    logic [COLOUR_W-1:0] w_colour;

    logic                r_plot;
    logic [COLOUR_W-1:0] r_colour;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;

    always_comb begin
        w_issue = (r_state == ST_SCAN);
        w_addr  = {r_row, r_col};
    end

    sprite_rom #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_rom (
        .clock  (clock),
        .addr   (w_addr),
        .colour (w_rom_colour)
    );

    // Control FSM: one address per SCAN cycle, two drain cycles, one done pulse.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_row       <= {RW{1'b0}};
            r_col       <= {CW{1'b0}};
            r_flush_cnt <= 1'b0;
            r_x0        <= {X_W{1'b0}};
            r_y0        <= {Y_W{1'b0}};
            r_erase     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_x0        <= x_in;
                        r_y0        <= y_in;
                        r_erase     <= erase;
                        r_row       <= {RW{1'b0}};
                        r_col       <= {CW{1'b0}};
                        r_flush_cnt <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SCAN;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    r_col <= r_col + COL_ONE;
                    if (r_col == COL_LAST) begin
                        r_row <= r_row + ROW_ONE;
                        if (r_row == ROW_LAST) begin
                            r_flush_cnt <= 1'b0;
                            r_state     <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_flush_cnt <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stage 1: address/valid delayed to line up with the registered ROM data.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_row   <= {RW{1'b0}};
            r_s1_col   <= {CW{1'b0}};
        end else begin
            r_s1_valid <= w_issue;
            r_s1_row   <= r_row;
            r_s1_col   <= r_col;
        end
    end

    always_comb begin
        w_px     = {1'b0, r_x0} + {{(X_W + 1 - CW){1'b0}}, r_s1_col};
        w_py     = {1'b0, r_y0} + {{(Y_W + 1 - RW){1'b0}}, r_s1_row};
        w_colour = r_erase ? BG_COLOUR : w_rom_colour;
        w_plot   = r_s1_valid && (w_rom_colour != TRANSPARENT) &&
                   on_screen(w_px, w_py, SCREEN_W, SCREEN_H);
    end

    // Stage 2: adapter outputs; coordinates and colour hold while plot is low.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_plot   <= 1'b0;
            r_colour <= {COLOUR_W{1'b0}};
            r_x      <= {X_W{1'b0}};
            r_y      <= {Y_W{1'b0}};
        end else begin
            r_plot <= w_plot;
            if (w_plot) begin
                r_colour <= w_colour;
                r_x      <= w_px[X_W-1:0];
                r_y      <= w_py[Y_W-1:0];
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign plot   = r_plot;
    assign colour = r_colour;
    assign x      = r_x;
    assign y      = r_y;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a reference model queues every expected
// pixel with its cycle, and a negedge monitor pops and compares each plot.
module tb_sprite_blitter;

    typedef struct packed {
        logic [31:0] cyc;
        logic [8:0]  x;
        logic [7:0]  y;
        logic [2:0]  col;
    } pix_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [8:0] x_in;
    logic [7:0] y_in;
    logic       erase;
    logic       busy;
    logic       done;
    logic       plot;
    logic [2:0] colour;
    logic [8:0] x;
    logic [7:0] y;

    int   total    = 0;
    int   bad      = 0;
    int   cyc      = 0;
    int   plot_cnt = 0;
    pix_t exp_q[$];
    pix_t mon_exp;
    pix_t mon_got;

    sprite_blitter dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .x_in   (x_in),
        .y_in   (y_in),
        .erase  (erase),
        .busy   (busy),
        .done   (done),
        .plot   (plot),
        .colour (colour),
        .x      (x),
        .y      (y)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (plot === 1'b1) begin
            plot_cnt++;
            total++;
            mon_got = '{cyc: 32'(cyc), x: x, y: y, col: colour};
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_plot: got cyc=%0d x=%0d y=%0d c=%0d, want no plot",
                         cyc, x, y, colour);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    bad++;
                    $display("FAIL pixel: got cyc=%0d x=%0d y=%0d c=%0d, want cyc=%0d x=%0d y=%0d c=%0d",
                             mon_got.cyc, mon_got.x, mon_got.y, mon_got.col,
                             mon_exp.cyc, mon_exp.x, mon_exp.y, mon_exp.col);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Reference: red border of an 8x8 sprite, clipped to 320x240, plot at c0+3+index.
    task automatic push_model(input int c0, input int x0, input int y0, input logic e);
        pix_t p;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if ((r == 0 || r == 7 || c == 0 || c == 7) &&
                    (x0 + c < 320) && (y0 + r < 240)) begin
                    p.cyc = 32'(c0 + 3 + r * 8 + c);
                    p.x   = 9'(x0 + c);
                    p.y   = 8'(y0 + r);
                    p.col = e ? 3'b111 : 3'b100;
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    task automatic issue(input int x0, input int y0, input logic e, output int c0);
        start = 1'b1;
        x_in  = 9'(x0);
        y_in  = 8'(y0);
        erase = e;
        c0    = cyc;
        push_model(c0, x0, y0, e);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int dc);
        dc = -1;
        for (int i = 0; i < bound; i++) begin
            if (done === 1'b1) begin
                dc = cyc;
                return;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step(3);
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (plot !== 1'b0)     begin bad++; $display("FAIL reset_plot: got %b want 0", plot); end
        total++; if (colour !== 3'b000) begin bad++; $display("FAIL reset_colour: got %0d want 0", colour); end
        total++; if (x !== 9'd0)        begin bad++; $display("FAIL reset_x: got %0d want 0", x); end
        total++; if (y !== 8'd0)        begin bad++; $display("FAIL reset_y: got %0d want 0", y); end
        resetn = 1'b1;
        step(1);
    endtask

    task automatic test_draw(input int x0, input int y0, input logic e, input int n_exp, input string nm);
        int c0, dc, pc;
        pc = plot_cnt;
        issue(x0, y0, e, c0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy_c1: got %b want 1", nm, busy); end
        wait_done(200, dc);
        total++; if (dc !== c0 + 67) begin bad++; $display("FAIL %s_done_cycle: got %0d want %0d", nm, dc - c0, 67); end
        step(1);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL %s_idle_c68: got busy=%b done=%b want 0 0", nm, busy, done);
        end
        total++; if (plot_cnt - pc !== n_exp) begin bad++; $display("FAIL %s_count: got %0d want %0d", nm, plot_cnt - pc, n_exp); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL %s_missing: got %0d left want 0", nm, exp_q.size()); end
    endtask

    task automatic test_busy_ignore();
        int c0, c1, dc, pc;
        pc = plot_cnt;
        issue(10, 20, 1'b0, c0);
        step(9);
        start = 1'b1; x_in = 9'd50; y_in = 8'd50;
        step(1);
        start = 1'b0;
        step(56);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_done_c67: got %b want 1", done); end
        start = 1'b1; x_in = 9'd50; y_in = 8'd50; erase = 1'b0;
        step(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy_c68: got %b want 0", busy); end
        c1 = cyc;
        push_model(c1, 50, 50, 1'b0);
        step(1);
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy_c69: got %b want 1", busy); end
        wait_done(200, dc);
        total++; if (dc !== c1 + 67) begin bad++; $display("FAIL ign_done2: got %0d want %0d", dc - c1, 67); end
        step(1);
        total++; if (plot_cnt - pc !== 56) begin bad++; $display("FAIL ign_count: got %0d want 56", plot_cnt - pc); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL ign_missing: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int c0, pc;
        issue(10, 20, 1'b0, c0);
        step(29);
        resetn = 1'b0;
        while (exp_q.size() > 0 && exp_q[$].cyc > 32'(c0 + 30)) exp_q.pop_back();
        step(1);
        total++; if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL mid_ctrl: got plot=%b busy=%b done=%b want 0 0 0", plot, busy, done);
        end
        total++; if (x !== 9'd0 || y !== 8'd0 || colour !== 3'd0) begin
            bad++; $display("FAIL mid_data: got x=%0d y=%0d c=%0d want 0 0 0", x, y, colour);
        end
        step(3);
        resetn = 1'b1;
        step(5);
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL mid_pre_reset: got %0d left want 0", exp_q.size()); end
        pc = plot_cnt;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_after: got %b want 0", busy); end
        test_draw(20, 30, 1'b1, 28, "after_rst");
        total++; if (plot_cnt - pc !== 28) begin bad++; $display("FAIL mid_count: got %0d want 28", plot_cnt - pc); end
    endtask

    task automatic test_held_start();
        int c0, pc;
        int d_q[$];
        pc    = plot_cnt;
        start = 1'b1; x_in = 9'd30; y_in = 8'd40; erase = 1'b0;
        c0    = cyc;
        push_model(c0, 30, 40, 1'b0);
        push_model(c0 + 68, 30, 40, 1'b0);
        for (int i = 0; i < 142; i++) begin
            if (done === 1'b1) d_q.push_back(cyc - c0);
            if (cyc - c0 == 100) start = 1'b0;
            @(negedge clock);
        end
        start = 1'b0;
        total++; if (d_q.size() !== 2) begin bad++; $display("FAIL held_done_n: got %0d want 2", d_q.size()); end
        total++; if (d_q.size() < 1 || d_q[0] !== 67) begin bad++; $display("FAIL held_done1: got %0d want 67", d_q.size() > 0 ? d_q[0] : -1); end
        total++; if (d_q.size() < 2 || d_q[1] !== 135) begin bad++; $display("FAIL held_done2: got %0d want 135", d_q.size() > 1 ? d_q[1] : -1); end
        total++; if (plot_cnt - pc !== 56) begin bad++; $display("FAIL held_count: got %0d want 56", plot_cnt - pc); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL held_missing: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        x_in   = 9'd0;
        y_in   = 8'd0;
        erase  = 1'b0;
        @(negedge clock);
        test_reset();
        test_draw(10, 20, 1'b0, 28, "draw");
        test_draw(10, 20, 1'b1, 28, "erase");
        test_draw(316, 236, 1'b0, 7, "clip");
        test_busy_ignore();
        test_reset_mid();
        test_held_start();
        step(4);
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL final_queue: got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
